// File: rtl/async_slave_burst.sv
// rtl/async_slave_burst.sv - burst 4-phase req/ack slave on a shared tristate bus
// Optional feature macro: ASYNC_SLAVE_PARITY_EN (adds an even-parity bit on data_bus).
module async_slave_burst #(
    parameter int DATA_W     = 4,
    parameter int BAUD_TICKS = 2,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic              req,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_in_rd,
    output logic [DATA_W-1:0] rcvd_data,
    output logic              rcvd_valid,
    output logic              ack,
    output logic              busy,
    output logic              err,
`ifdef ASYNC_SLAVE_PARITY_EN
    inout  wire  [DATA_W:0]   data_bus
`else
    inout  wire  [DATA_W-1:0] data_bus
`endif
);

`ifdef ASYNC_SLAVE_PARITY_EN
    localparam int BUS_W = DATA_W + 1;
`else
    localparam int BUS_W = DATA_W;
`endif
    localparam int WC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_XFER = 3'd2,
        S_ACK  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  tick;
    logic [WC_W-1:0]   word_cnt;
    logic              rw_lat;
    logic              bus_oe;
    logic              capture;
    logic              par_bad;
    logic [BUS_W-1:0]  bus_out;

    wire tick_last   = (tick == CNT_W'(BAUD_TICKS - 1));
    wire timeout_hit = (tick == CNT_W'(TIMEOUT - 1));
    wire word_last   = (word_cnt == WC_W'(BURST_LEN - 1));

`ifdef ASYNC_SLAVE_PARITY_EN
    assign bus_out = {^data_in, data_in};
    assign par_bad = data_bus[DATA_W] != (^data_bus[DATA_W-1:0]);
`else
    assign bus_out = data_in;
    assign par_bad = 1'b0;
`endif

    assign data_bus = bus_oe ? bus_out : {BUS_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req has priority over the WAIT timeout; a dropped req in TRANSFER aborts the burst
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_WAIT;
            S_WAIT: begin
                if (req)              state_next = S_XFER;
                else if (timeout_hit) state_next = S_IDLE;
            end
            S_XFER: begin
                if (!req)           state_next = S_IDLE;
                else if (tick_last) state_next = S_ACK;
            end
            S_ACK:  if (!req) state_next = word_last ? S_DONE : S_WAIT;
            S_DONE: if (tick_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ack        = (state == S_ACK);
        busy       = (state != S_IDLE);
        bus_oe     = (state == S_XFER) && !rw_lat;
        data_in_rd = (state == S_XFER) && req && tick_last && !rw_lat;
        capture    = (state == S_XFER) && req && tick_last && rw_lat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick       <= '0;
            word_cnt   <= '0;
            rw_lat     <= 1'b0;
            rcvd_data  <= '0;
            rcvd_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (state_next != state)
                tick <= '0;
            else if (tick != {CNT_W{1'b1}})
                tick <= tick + 1'b1;

            if (state == S_IDLE && start) begin
                rw_lat   <= rw;
                word_cnt <= '0;
            end else if (state == S_ACK && !req) begin
                word_cnt <= word_last ? '0 : word_cnt + 1'b1;
            end

            rcvd_valid <= capture;
            if (capture)
                rcvd_data <= data_bus[DATA_W-1:0];

            err <= (state == S_WAIT && !req && timeout_hit)
                || (state == S_XFER && !req)
                || (capture && par_bad);
        end
    end

endmodule

// File: tb/tb_async_slave_burst.sv
// tb/tb_async_slave_burst.sv - randomized bench for async_slave_burst against a phase-timeline model
module tb_async_slave_burst;

    localparam int DATA_W     = 4;
    localparam int BAUD_TICKS = 2;
    localparam int BURST_LEN  = 4;
    localparam int TIMEOUT    = 16;
    localparam int CNT_W      = 13;
`ifdef ASYNC_SLAVE_PARITY_EN
    localparam int BUS_W = DATA_W + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int BUS_W = DATA_W;
    localparam bit PAR   = 1'b0;
`endif
    localparam int NONE   = -1;
    localparam int M_NONE = 0;
    localparam int M_SLV  = 1;
    localparam int M_MST  = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic              rw;
    logic              req;
    logic [DATA_W-1:0] data_in;
    logic              data_in_rd;
    logic [DATA_W-1:0] rcvd_data;
    logic              rcvd_valid;
    logic              ack;
    logic              busy;
    logic              err;
    wire  [BUS_W-1:0]  data_bus;

    logic              men;
    logic [BUS_W-1:0]  mdrv;
    assign data_bus = men ? mdrv : {BUS_W{1'bz}};

    async_slave_burst #(
        .DATA_W(DATA_W), .BAUD_TICKS(BAUD_TICKS), .BURST_LEN(BURST_LEN),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .req(req),
        .data_in(data_in), .data_in_rd(data_in_rd), .rcvd_data(rcvd_data),
        .rcvd_valid(rcvd_valid), .ack(ack), .busy(busy), .err(err),
        .data_bus(data_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic              p_rv, p_err, noise;
    logic [DATA_W-1:0] p_data, last_rdata;
    logic [DATA_W-1:0] wd [BURST_LEN];
    int                gap_v [BURST_LEN];
    int                rxv [4] = '{3, 5, 10, 15};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [BUS_W-1:0] busword(input logic [DATA_W-1:0] d, input logic bad);
        logic [DATA_W:0] full;
        full = {(^d) ^ bad, d};
        return full[BUS_W-1:0];
    endfunction

    // One clock cycle: drive inputs, check expected outputs, record registered outputs due next cycle.
    task automatic cyc(input logic st, input logic rq, input int mode, input logic [BUS_W-1:0] mw,
                       input logic e_ack, input logic e_busy, input logic e_rd,
                       input logic n_rv, input logic n_err, input logic [DATA_W-1:0] n_data);
        logic [BUS_W-1:0] e_bus;
        if (noise) begin
            start = 1'($urandom_range(0, 1));
            rw    = 1'($urandom_range(0, 1));
        end else begin
            start = st;
        end
        req  = rq;
        men  = (mode != M_SLV);
        mdrv = (mode == M_MST) ? mw : '0;
        #1;
        e_bus = (mode == M_SLV) ? busword(data_in, 1'b0) : ((mode == M_MST) ? mw : '0);
        if (p_rv) last_rdata = p_data;
        check("ack", 32'(ack), 32'(e_ack));
        check("busy", 32'(busy), 32'(e_busy));
        check("data_in_rd", 32'(data_in_rd), 32'(e_rd));
        check("rcvd_valid", 32'(rcvd_valid), 32'(p_rv));
        check("err", 32'(err), 32'(p_err));
        check("rcvd_data", 32'(rcvd_data), 32'(last_rdata));
        check("data_bus", 32'(data_bus), 32'(e_bus));
        p_rv   = n_rv;
        p_err  = n_err;
        p_data = n_data;
        @(negedge clk);
    endtask

    // Burst timeline: IDLE+start, per word WAIT(gap)/TRANSFER(BAUD)/ACK(hold+1), then DONE(BAUD).
    task automatic burst(input logic rwv, input int abort_w, input int abort_c,
                         input int tmo_w, input int bad_w);
        logic [BUS_W-1:0] mw;
        logic             last;
        int               hold;
        int               mode;
        noise   = 1'b0;
        rw      = rwv;
        data_in = rwv ? DATA_W'($urandom_range(1, (1 << DATA_W) - 1)) : wd[0];
        cyc(1'b1, 1'b0, M_NONE, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        noise = 1'b1;
        mode  = rwv ? M_MST : M_SLV;
        for (int w = 0; w < BURST_LEN; w++) begin
            if (!rwv) data_in = wd[w];
            if (w == tmo_w) begin
                for (int i = 0; i < TIMEOUT; i++)
                    cyc(1'b0, 1'b0, M_NONE, '0, 1'b0, 1'b1, 1'b0, 1'b0, i == TIMEOUT - 1, '0);
                noise = 1'b0;
                return;
            end
            for (int i = 0; i < gap_v[w]; i++)
                cyc(1'b0, 1'b0, M_NONE, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            cyc(1'b0, 1'b1, M_NONE, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            mw = busword(wd[w], w == bad_w);
            for (int c = 0; c < BAUD_TICKS; c++) begin
                last = (c == BAUD_TICKS - 1);
                if (w == abort_w && c == abort_c) begin
                    cyc(1'b0, 1'b0, mode, mw, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
                    noise = 1'b0;
                    return;
                end
                cyc(1'b0, 1'b1, mode, mw, 1'b0, 1'b1, last && !rwv,
                    last && rwv, last && rwv && (w == bad_w) && PAR, wd[w]);
            end
            hold = $urandom_range(0, 2);
            for (int j = 0; j < hold; j++)
                cyc(1'b0, 1'b1, M_NONE, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            cyc(1'b0, 1'b0, M_NONE, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        end
        for (int c = 0; c < BAUD_TICKS; c++)
            cyc(1'b0, 1'b0, M_NONE, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        noise = 1'b0;
    endtask

    task automatic fill_random();
        for (int w = 0; w < BURST_LEN; w++) begin
            wd[w]    = DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
            gap_v[w] = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
        end
    endtask

    task automatic idle_cycle();
        cyc(1'b0, 1'b0, M_NONE, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rw = 1'b0; req = 1'b0; data_in = '0;
        men = 1'b1; mdrv = '0; noise = 1'b0;
        p_rv = 1'b0; p_err = 1'b0; p_data = '0; last_rdata = '0;
        repeat (2) @(negedge clk);
        idle_cycle();
        rst = 1'b0;

        for (int w = 0; w < BURST_LEN; w++) begin
            wd[w] = DATA_W'(rxv[w % 4]);
            gap_v[w] = w;
        end
        burst(1'b1, NONE, 0, NONE, NONE);

        for (int w = 0; w < BURST_LEN; w++) wd[w] = DATA_W'(w + 1);
        burst(1'b0, NONE, 0, NONE, NONE);

        burst(1'b1, NONE, 0, 0, NONE);
        gap_v[0] = TIMEOUT - 1;
        burst(1'b1, NONE, 0, NONE, NONE);

        fill_random();
        burst(1'b1, 1, 0, NONE, NONE);

        // reset while the slave drives the bus in TRANSFER
        rw = 1'b0; data_in = DATA_W'(5);
        cyc(1'b1, 1'b0, M_NONE, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, M_NONE, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, M_SLV, '0, 1'b0, 1'b1, BAUD_TICKS == 1, 1'b0, 1'b0, '0);
        rst = 1'b0;
        last_rdata = '0;
        idle_cycle();

`ifdef ASYNC_SLAVE_PARITY_EN
        fill_random();
        wd[0] = DATA_W'(7);
        burst(1'b1, NONE, 0, NONE, 0);
`endif

        for (int n = 0; n < 30; n++) begin
            fill_random();
            burst(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, BURST_LEN - 1) : NONE,
                  $urandom_range(0, BAUD_TICKS - 1),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, BURST_LEN - 1) : NONE,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, BURST_LEN - 1) : NONE);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
